serial_uart_tx: RTL

- Memory-mapped UART transmitter; sits directly downstream of the CPU data-memory bus, behind the MMU serial select.
- Accepts bytes written by the CPU into a TX FIFO and serialises them onto a single TX line as 8N1 frames.
- Exposes a status word so software can poll for free space and overflow.
- Replaces the write-only serial sink with a physical UART output.

---
 rtl/serial_uart_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/serial_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU writes fill a TX FIFO, a bit-timing FSM
// drains it onto a registered, idle-high serial line. STATUS exposes empty/full/busy/overflow.
module serial_uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        tx,
    output logic        busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [15:0]   TICK_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    state_t        state_q;
    logic [15:0]   baud_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    logic wr_data, wr_stat, full, empty, push, pop, tick;
    logic unused_bits;

    assign wr_data = sel & we & ~addr[2];
    assign wr_stat = sel & we & addr[2];
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push    = wr_data & ~full;
    assign tick    = (baud_q == TICK_LAST);
    // A pop is an FSM decision: load from IDLE, or chain directly out of the stop bit.
    assign pop     = ~empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & tick));

    assign busy = (state_q != S_IDLE) | ~empty;
    assign tx   = tx_q;
    assign dout = (sel & addr[2]) ? {28'b0, ovf_q, busy, full, empty} : 32'b0;

    assign unused_bits = ^{addr[31:3], addr[1:0], din[31:8]};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (wr_data & full)  ovf_d = 1'b1;
        if (wr_stat & din[0]) ovf_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= din[7:0];
    end

    // tx_q is loaded with the level of the state being entered, so the line is glitch-free.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem[rd_ptr_q];
                        baud_q  <= '0;
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        baud_q  <= '0;
                        idx_q   <= '0;
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= mem[rd_ptr_q];
                            state_q <= S_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule
